// File: rtl/par9_serial_checker.sv
// Serial receive stage: assembles 9-bit frames (8 data bits followed by a parity bit),
// checks the parity and presents each byte on a valid/ready output with error statistics.
module par9_serial_checker #(
    parameter int ODD_PARITY = 1,
    parameter int MSB_FIRST  = 0,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SIN,
    input  logic             SEN,
    input  logic             SOF,
    output logic [7:0]       DOUT,
    output logic             PAR_ERR,
    output logic             DVALID,
    input  logic             DREADY,
    output logic             OVERRUN,
    output logic [CNT_W-1:0] ERR_CNT,
    input  logic             CLR_CNT,
    output logic             dbg_state
);

    // Output handshake: a word moves on a cycle where DVALID=1 and DREADY=1; while
    // DVALID=1 and DREADY=0 the word is held stable; DREADY is ignored while DVALID=0.
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [7:0]       sh_q, sh_d;
    logic             frame_done;

    logic [7:0]       dout_q, dout_d;
    logic             par_err_q, par_err_d;
    logic             dvalid_q, dvalid_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [7:0]       word_data;
    logic             word_x;
    logic             word_err;
    logic             load;
    logic             drop;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            sh_q      <= 8'd0;
            dout_q    <= 8'd0;
            par_err_q <= 1'b0;
            dvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            dout_q    <= dout_d;
            par_err_q <= par_err_d;
            dvalid_q  <= dvalid_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Bit assembly; the parity bit is never stored, it is used straight from SIN.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        frame_done = 1'b0;
        if (SOF) begin
            if (SEN) begin
                sh_d[0] = SIN;
                cnt_d   = 4'd1;
                state_d = SHIFT;
            end else begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        end else if (SEN) begin
            if (cnt_q == 4'd8) begin
                frame_done = 1'b1;
                cnt_d      = 4'd0;
                state_d    = IDLE;
            end else begin
                sh_d[cnt_q[2:0]] = SIN;
                cnt_d            = cnt_q + 4'd1;
                state_d          = SHIFT;
            end
        end
    end

    always_comb begin
        word_data = 8'd0;
        for (int i = 0; i < 8; i++) begin
            word_data[i] = (MSB_FIRST != 0) ? sh_q[7-i] : sh_q[i];
        end
        word_x   = (^sh_q) ^ SIN;
        word_err = (ODD_PARITY != 0) ? ~word_x : word_x;
        load     = frame_done & (~dvalid_q | DREADY);
        drop     = frame_done & dvalid_q & ~DREADY;

        dout_d    = dout_q;
        par_err_d = par_err_q;
        dvalid_d  = dvalid_q;
        if (load) begin
            dout_d    = word_data;
            par_err_d = word_err;
            dvalid_d  = 1'b1;
        end else if (dvalid_q && DREADY) begin
            dvalid_d  = 1'b0;
        end

        // A clear beats a coincident increment or overrun event.
        err_cnt_d = err_cnt_q;
        overrun_d = overrun_q | drop;
        if (CLR_CNT) begin
            err_cnt_d = '0;
            overrun_d = 1'b0;
        end else if (load && word_err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    assign DOUT      = dout_q;
    assign PAR_ERR   = par_err_q;
    assign DVALID    = dvalid_q;
    assign OVERRUN   = overrun_q;
    assign ERR_CNT   = err_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_par9_serial_checker.sv
// Directed bench: three configurations share one input stream; each step checks the
// instance it targets against hand-computed values.
module tb_par9_serial_checker;
  logic clk;
  logic rst;
  logic sin;
  logic sen;
  logic sof;
  logic dready;
  logic clr_cnt;

  logic [7:0] a_dout, b_dout, c_dout;
  logic       a_perr, b_perr, c_perr;
  logic       a_dvalid, b_dvalid, c_dvalid;
  logic       a_ovr, b_ovr, c_ovr;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;
  logic       a_st, b_st, c_st;

  int total;
  int bad;

  par9_serial_checker #(.ODD_PARITY(1), .MSB_FIRST(0), .CNT_W(8)) dut_a (
    .CLK(clk), .RST(rst), .SIN(sin), .SEN(sen), .SOF(sof),
    .DOUT(a_dout), .PAR_ERR(a_perr), .DVALID(a_dvalid), .DREADY(dready),
    .OVERRUN(a_ovr), .ERR_CNT(a_cnt), .CLR_CNT(clr_cnt), .dbg_state(a_st)
  );

  par9_serial_checker #(.ODD_PARITY(0), .MSB_FIRST(1), .CNT_W(8)) dut_b (
    .CLK(clk), .RST(rst), .SIN(sin), .SEN(sen), .SOF(sof),
    .DOUT(b_dout), .PAR_ERR(b_perr), .DVALID(b_dvalid), .DREADY(dready),
    .OVERRUN(b_ovr), .ERR_CNT(b_cnt), .CLR_CNT(clr_cnt), .dbg_state(b_st)
  );

  par9_serial_checker #(.ODD_PARITY(1), .MSB_FIRST(0), .CNT_W(2)) dut_c (
    .CLK(clk), .RST(rst), .SIN(sin), .SEN(sen), .SOF(sof),
    .DOUT(c_dout), .PAR_ERR(c_perr), .DVALID(c_dvalid), .DREADY(dready),
    .OVERRUN(c_ovr), .ERR_CNT(c_cnt), .CLR_CNT(clr_cnt), .dbg_state(c_st)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic start);
    sin = b;
    sen = 1'b1;
    sof = start;
    tick();
    sen = 1'b0;
    sof = 1'b0;
  endtask

  // bit i of the frame: data bit d[i] (or d[7-i] when msb), bit 8 is the parity bit p
  task automatic send_word(input logic [7:0] d, input logic p, input logic msb,
                           input int nbits, input logic start);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      if (i == 8) b = p;
      else if (msb) b = d[7-i];
      else b = d[i];
      send_bit(b, start && (i == 0));
    end
  endtask

  initial begin
    logic [1:0] sat_exp [4];
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    sin     = 1'b0;
    sen     = 1'b0;
    sof     = 1'b0;
    dready  = 1'b0;
    clr_cnt = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_dvalid", a_dvalid, 1'b0);
    chk("rst_dout", a_dout, 8'h00);
    chk("rst_cnt", a_cnt, 8'd0);
    chk("rst_ovr", a_ovr, 1'b0);
    chk("rst_state", a_st, 1'b0);

    // 0xA5 LSB first, good odd parity, held with DREADY=0
    send_word(8'hA5, 1'b1, 1'b0, 9, 1'b0);
    chk("a5_dvalid", a_dvalid, 1'b1);
    chk("a5_dout", a_dout, 8'hA5);
    chk("a5_perr", a_perr, 1'b0);
    chk("a5_cnt", a_cnt, 8'd0);
    tick();
    chk("a5_hold_dout", a_dout, 8'hA5);
    dready = 1'b1;
    tick();
    chk("a5_xfer_dvalid", a_dvalid, 1'b0);

    // same byte with bad parity, consumer ready
    send_word(8'hA5, 1'b0, 1'b0, 9, 1'b0);
    chk("bad_perr", a_perr, 1'b1);
    chk("bad_dvalid", a_dvalid, 1'b1);
    chk("bad_cnt", a_cnt, 8'd1);
    tick();
    chk("bad_gone", a_dvalid, 1'b0);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_cnt", a_cnt, 8'd0);

    // even parity, MSB first: 0x3C
    do_reset();
    send_word(8'h3C, 1'b0, 1'b1, 9, 1'b0);
    chk("b_dout", b_dout, 8'h3C);
    chk("b_perr", b_perr, 1'b0);
    chk("b_cnt", b_cnt, 8'd0);
    tick();
    send_word(8'h3C, 1'b1, 1'b1, 9, 1'b0);
    chk("b_bad_perr", b_perr, 1'b1);
    chk("b_bad_cnt", b_cnt, 8'd1);

    // overrun: 0x11 held, 0x22 dropped
    do_reset();
    dready = 1'b0;
    send_word(8'h11, 1'b1, 1'b0, 9, 1'b0);
    send_word(8'h22, 1'b1, 1'b0, 9, 1'b0);
    chk("ovr_dout", a_dout, 8'h11);
    chk("ovr_flag", a_ovr, 1'b1);
    chk("ovr_dvalid", a_dvalid, 1'b1);
    dready = 1'b1;
    tick();
    dready = 1'b0;
    chk("ovr_xfer", a_dvalid, 1'b0);
    chk("ovr_sticky", a_ovr, 1'b1);

    // completion on a transfer cycle: no bubble, no overrun growth
    send_word(8'h11, 1'b1, 1'b0, 9, 1'b0);
    send_word(8'h22, 1'b1, 1'b0, 8, 1'b0);
    dready = 1'b1;
    send_bit(1'b1, 1'b0);
    chk("nobub_dvalid", a_dvalid, 1'b1);
    chk("nobub_dout", a_dout, 8'h22);
    tick();
    chk("nobub_after", a_dvalid, 1'b0);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_ovr", a_ovr, 1'b0);

    // SOF with SEN restarts assembly after a partial frame
    do_reset();
    dready = 1'b0;
    send_word(8'hFF, 1'b0, 1'b0, 5, 1'b0);
    send_word(8'h5A, 1'b1, 1'b0, 8, 1'b1);
    chk("sof_no_early", a_dvalid, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("sof_dout", a_dout, 8'h5A);
    chk("sof_perr", a_perr, 1'b0);
    chk("sof_cnt", a_cnt, 8'd0);

    // SOF without SEN discards the partial frame
    do_reset();
    dready = 1'b1;
    send_word(8'hFF, 1'b0, 1'b0, 3, 1'b0);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    send_word(8'h3C, 1'b1, 1'b0, 9, 1'b0);
    chk("sof0_dout", a_dout, 8'h3C);
    chk("sof0_dvalid", a_dvalid, 1'b1);

    // reset mid-frame with a word held
    do_reset();
    dready = 1'b0;
    send_word(8'hA5, 1'b0, 1'b0, 9, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0, 4, 1'b0);
    chk("mid_state", a_st, 1'b1);
    do_reset();
    chk("mid_rst_dvalid", a_dvalid, 1'b0);
    chk("mid_rst_dout", a_dout, 8'h00);
    chk("mid_rst_perr", a_perr, 1'b0);
    chk("mid_rst_cnt", a_cnt, 8'd0);
    chk("mid_rst_state", a_st, 1'b0);
    send_word(8'h5A, 1'b1, 1'b0, 9, 1'b0);
    chk("mid_new_dout", a_dout, 8'h5A);
    chk("mid_new_perr", a_perr, 1'b0);

    // 2-bit counter saturation
    do_reset();
    dready = 1'b1;
    sat_exp[0] = 2'd1;
    sat_exp[1] = 2'd2;
    sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3;
    for (int k = 0; k < 4; k++) begin
      send_word(8'hA5, 1'b0, 1'b0, 9, 1'b0);
      chk($sformatf("sat_%0d", k), c_cnt, sat_exp[k]);
    end
    chk("sat_wide_cnt", a_cnt, 8'd4);
    send_word(8'hA5, 1'b0, 1'b0, 8, 1'b0);
    clr_cnt = 1'b1;
    send_bit(1'b0, 1'b0);
    clr_cnt = 1'b0;
    chk("clr_vs_inc_c", c_cnt, 2'd0);
    chk("clr_vs_inc_a", a_cnt, 8'd0);
    chk("clr_keeps_perr", a_perr, 1'b1);
    send_word(8'hA5, 1'b0, 1'b0, 9, 1'b0);
    chk("after_clr_c", c_cnt, 2'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/par9_serial_checker.md
Name: par9_serial_checker

Overview:
- Serial-to-parallel receive stage that assembles 9-bit frames (8 data bits plus 1 parity bit) from a bit stream.
- Checks each frame using the 9-input parity function: XNOR9 of all 9 bits = 1 when the count of ones is even.
- Presents each checked byte on a valid/ready output with a per-word parity-error flag, a sticky overrun flag and a saturating error counter.
- Sits directly upstream of the 9-input parity macro and downstream of the serial link front end.

Parameters:
ODD_PARITY, 1, 1 = odd parity expected (ones count over all 9 bits is odd); 0 = even parity expected
MSB_FIRST, 0, 0 = first data bit received is D0; 1 = first data bit received is D7
CNT_W, 8, width of the parity-error counter (range 2..16)

Ports:
CLK  input  1  single clock; all logic on the rising edge
RST  input  1  synchronous, active-high reset
SIN  input  1  serial data bit
SEN  input  1  SIN is valid this cycle
SOF  input  1  start of frame; restarts bit assembly
DOUT  output  8  received data byte
PAR_ERR  output  1  parity error for the word on DOUT; valid while DVALID=1
DVALID  output  1  DOUT/PAR_ERR hold a word
DREADY  input  1  consumer accepts the word
OVERRUN  output  1  sticky: a completed word was dropped
ERR_CNT  output  CNT_W  count of loaded words with PAR_ERR=1
CLR_CNT  input  1  clears ERR_CNT and OVERRUN

Behaviour:
- Reset:
  - RST sampled high clears everything: DOUT=0, PAR_ERR=0, DVALID=0, OVERRUN=0, ERR_CNT=0.
  - Shift register and bit counter are cleared; the state machine goes to IDLE.
  - RST overrides every other input, including mid-frame; the partial frame is discarded.
- State machine:
  - IDLE: counter=0. SEN=1 captures bit 0 and moves to SHIFT.
  - SHIFT: each SEN=1 captures the next bit and increments the counter.
  - When the 9th bit (the parity bit) is captured, the frame is complete and the state returns to IDLE.
  - SEN=0 holds state; there is no timeout.
- SOF:
  - SOF=1 with SEN=1: the partial frame is discarded and SIN is taken as bit 0 of a new frame (counter becomes 1).
  - SOF=1 with SEN=0: the partial frame is discarded, counter=0, state IDLE.
  - A discarded frame produces no output and no error count.
- Bit order:
  - Bits 0..7 are data. MSB_FIRST=0 maps received bit i to D[i]; MSB_FIRST=1 maps received bit i to D[7-i].
  - Bit 8 is always the parity bit.
- Parity:
  - x = XOR of all 9 bits.
  - ODD_PARITY=1: error when x=0, i.e. XNOR9 output = 1.
  - ODD_PARITY=0: error when x=1.
- Latency: DVALID, DOUT and PAR_ERR update on the clock edge that samples the 9th bit, so they are visible the next cycle (1-cycle latency).
- Output handshake:
  - A transfer occurs on a cycle where DVALID=1 and DREADY=1.
  - While DVALID=1 and DREADY=0, DOUT and PAR_ERR are held stable.
  - After a transfer with no new word, DVALID=0 on the next cycle.
  - DREADY is ignored while DVALID=0.
- Word completion (a completed frame is "loaded" into the output register, or dropped):
  - Completion with DVALID=0: the word is loaded.
  - Completion on the same cycle as a transfer: the new word is loaded and DVALID stays 1 with no bubble.
  - Completion with DVALID=1 and DREADY=0: the new word is dropped, the held word is unchanged and OVERRUN is set.
- ERR_CNT:
  - Increments by 1 whenever a word with a parity error is loaded. Dropped words are not counted.
  - Saturates at 2^CNT_W-1 and does not wrap.
- CLR_CNT:
  - Sets ERR_CNT=0 and OVERRUN=0 on the next edge.
  - If a clear coincides with an increment or an overrun event, the clear wins.
  - DVALID, DOUT and PAR_ERR are unaffected.

Test Plan:
- ODD_PARITY=1, MSB_FIRST=0: send LSB-first 1,0,1,0,0,1,0,1 (0xA5) then parity bit 1 → one cycle after the 9th bit, DVALID=1, DOUT=0xA5, PAR_ERR=0, ERR_CNT=0.
- Same frame with parity bit 0 and DREADY=1 → PAR_ERR=1 for one cycle, ERR_CNT=1. Then CLR_CNT pulse → ERR_CNT=0.
- ODD_PARITY=0, MSB_FIRST=1: send 0x3C MSB first (0,0,1,1,1,1,0,0) then parity 0 → DOUT=0x3C, PAR_ERR=0.
- DREADY=0: send 0x11 then 0x22, both with correct parity → DOUT stays 0x11, OVERRUN=1. Raise DREADY → one transfer of 0x11, then DVALID=0.
- Send 5 bits, then SOF=1 with SEN=1 starting a fresh 0x5A frame → only 0x5A is output and ERR_CNT is unchanged. Separately, RST asserted after 4 bits → all outputs 0 and the next 9 bits form a clean frame.
- CNT_W=2: send 4 frames with bad parity and DREADY=1 → ERR_CNT sequence 1,2,3,3 (saturates). CLR_CNT asserted on the same cycle as an increment → ERR_CNT=0.
